// File: rtl/click_src_bridge.sv
`timescale 1ns/1ps
// click_src_bridge
// Head of the click network: takes words from the clocked host on a
// valid/ready port and launches each as a two-phase bundled-data token
// (out_reqR toggle with out_data held stable). The next word is not taken
// until the downstream acknowledge phase, seen through a synchronizer,
// matches the request phase again.
module click_src_bridge #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              out_reqR,
    output logic [DATA_W-1:0] out_data,
    input  logic              in_ackR,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_tok_cnt,
    output logic              o_proto_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   req_ph;
    logic                   ack_match;

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign ack_match = (ack_s == req_ph);
    assign out_reqR  = req_ph;

    // Bring the asynchronous acknowledge into the clock domain before any use
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], in_ackR};
        end
    end

    // Token handshake sequencer with registered ready/busy, counter and error flag
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= IDLE;
            req_ph      <= 1'b0;
            out_data    <= '0;
            o_ready     <= 1'b1;
            o_busy      <= 1'b0;
            o_tok_cnt   <= '0;
            o_proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!ack_match) begin
                        o_proto_err <= 1'b1;
                    end
                    if (i_valid) begin
                        out_data <= i_data;
                        state    <= SETUP;
                        o_ready  <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end
                SETUP: begin
                    if (!ack_match) begin
                        o_proto_err <= 1'b1;
                    end
                    req_ph <= ~req_ph;
                    state  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (ack_match) begin
                        o_tok_cnt <= o_tok_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        state     <= IDLE;
                        o_ready   <= 1'b1;
                        o_busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_click_src_bridge.sv
`timescale 1ns/1ps
// tb_click_src_bridge
// Directed bench for the synchronous-to-click bridge. A downstream click
// sink echoes the request phase after a programmable delay and records the
// bundled data it sees. A token-lifecycle model predicts every output and
// is compared on each falling clock edge; literal checks pin the model.
module tb_click_src_bridge;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;

    logic              i_clk;
    logic              i_rstn;
    logic              i_valid;
    logic [DATA_W-1:0] i_data;
    logic              o_ready;
    logic              out_reqR;
    logic [DATA_W-1:0] out_data;
    logic              in_ackR;
    logic              o_busy;
    logic [CNT_W-1:0]  o_tok_cnt;
    logic              o_proto_err;

    int errors = 0;
    int checks = 0;

    logic              ackPh     = 1'b0;
    logic              errInject = 1'b0;
    int                ackDelay  = 3;
    int                sinkGen   = 0;
    int                toggleCnt = 0;
    logic [DATA_W-1:0] sinkData[$];

    assign in_ackR = ackPh ^ errInject;

    click_src_bridge #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .o_ready     (o_ready),
        .out_reqR    (out_reqR),
        .out_data    (out_data),
        .in_ackR     (in_ackR),
        .o_busy      (o_busy),
        .o_tok_cnt   (o_tok_cnt),
        .o_proto_err (o_proto_err)
    );

    // 100 MHz host clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Downstream click sink: capture data on each new request phase, echo the phase later
    always @(out_reqR) begin : sink
        int g;
        if (i_rstn === 1'b1 && out_reqR !== ackPh) begin
            g = sinkGen;
            sinkData.push_back(out_data);
            #(ackDelay);
            if (g == sinkGen) ackPh = out_reqR;
        end
    end

    // Downstream phase flops share the bridge reset
    always @(negedge i_rstn) begin
        ackPh = 1'b0;
        sinkGen++;
    end

    // Count request toggles made outside reset
    always @(out_reqR) begin
        if (i_rstn === 1'b1) toggleCnt++;
    end

    // Token lifecycle model: a token is taken when idle, launched one edge later,
    // and retired on the first later edge where the delayed acknowledge equals the phase
    logic              mInflight;
    logic              mLaunched;
    logic              mPhase;
    logic              mErr;
    logic [DATA_W-1:0] mData;
    int                mCnt;
    logic              mAckHist[SYNC_STAGES];

    always @(posedge i_clk or negedge i_rstn) begin : model
        logic delayed;
        if (!i_rstn) begin
            mInflight = 1'b0;
            mLaunched = 1'b0;
            mPhase    = 1'b0;
            mErr      = 1'b0;
            mData     = '0;
            mCnt      = 0;
            for (int i = 0; i < SYNC_STAGES; i++) mAckHist[i] = 1'b0;
        end else begin
            delayed = mAckHist[SYNC_STAGES-1];
            for (int i = SYNC_STAGES-1; i > 0; i--) mAckHist[i] = mAckHist[i-1];
            mAckHist[0] = in_ackR;
            if (!mInflight) begin
                if (delayed != mPhase) mErr = 1'b1;
                if (i_valid) begin
                    mInflight = 1'b1;
                    mLaunched = 1'b0;
                    mData     = i_data;
                end
            end else if (!mLaunched) begin
                if (delayed != mPhase) mErr = 1'b1;
                mPhase    = ~mPhase;
                mLaunched = 1'b1;
            end else if (delayed == mPhase) begin
                mInflight = 1'b0;
                mCnt      = mCnt + 1;
            end
        end
    end

    // Compare every output against the model away from the rising edge
    always @(negedge i_clk) begin
        checkOutput("model_ready",    o_ready,     !mInflight);
        checkOutput("model_busy",     o_busy,      mInflight);
        checkOutput("model_reqR",     out_reqR,    mPhase);
        checkOutput("model_data",     out_data,    mData);
        checkOutput("model_tok_cnt",  o_tok_cnt,   mCnt % (1 << CNT_W));
        checkOutput("model_proto_err", o_proto_err, mErr);
    end

    task automatic waitReady(input int budget);
        int n = 0;
        while (o_ready !== 1'b1 && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (o_ready !== 1'b1) checkOutput("ready_timeout", o_ready, 1);
    endtask

    // Offer one word and return on the falling edge after it is accepted
    task automatic applyStimulus(input logic [DATA_W-1:0] word);
        waitReady(100);
        i_data  = word;
        i_valid = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge i_clk);
        #2 i_rstn = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            i_valid   = 1'($urandom_range(0, 1));
            i_data    = 8'($urandom_range(0, 255));
            errInject = 1'($urandom_range(0, 1));
        end
        @(negedge i_clk);
        checkOutput("rst_reqR",      out_reqR,    0);
        checkOutput("rst_data",      out_data,    0);
        checkOutput("rst_ready",     o_ready,     1);
        checkOutput("rst_busy",      o_busy,      0);
        checkOutput("rst_tok_cnt",   o_tok_cnt,   0);
        checkOutput("rst_proto_err", o_proto_err, 0);
        i_valid   = 1'b0;
        errInject = 1'b0;
        ackDelay  = 3;
        #2 i_rstn = 1'b1;
        @(negedge i_clk);
        sinkData.delete();
    endtask

    // Runaway guard
    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : stim
        int t0;
        i_rstn  = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;

        // Reset with random inputs
        applyReset();

        // Single token with fast acknowledge
        t0 = toggleCnt;
        applyStimulus(8'hA5);
        checkOutput("single_data_n",  out_data, 8'hA5);
        checkOutput("single_reqR_n",  out_reqR, 0);
        checkOutput("single_ready_n", o_ready,  0);
        @(negedge i_clk);
        checkOutput("single_reqR_n1", out_reqR, 1);
        @(negedge i_clk);
        checkOutput("single_ready_n2", o_ready, 0);
        @(negedge i_clk);
        checkOutput("single_ready_n3", o_ready, 0);
        @(negedge i_clk);
        checkOutput("single_ready_n4", o_ready,   1);
        checkOutput("single_tok_cnt",  o_tok_cnt, 1);
        checkOutput("single_toggles",  toggleCnt - t0, 1);
        checkOutput("single_sink_data", sinkData.size() > 0 ? sinkData[0] : 8'h00, 8'hA5);

        // Back-to-back with valid held high
        applyReset();
        t0 = toggleCnt;
        for (int k = 1; k <= 8; k++) begin
            waitReady(100);
            i_data  = 8'(k);
            i_valid = 1'b1;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        waitReady(100);
        checkOutput("b2b_toggles",   toggleCnt - t0, 8);
        checkOutput("b2b_sink_count", sinkData.size(), 8);
        for (int k = 0; k < 8 && k < sinkData.size(); k++) begin
            checkOutput($sformatf("b2b_sink_word%0d", k), sinkData[k], k + 1);
        end
        checkOutput("b2b_tok_cnt", o_tok_cnt, 8);
        checkOutput("b2b_reqR",    out_reqR,  0);

        // Backpressure: acknowledge 20 cycles late, a competing word is offered meanwhile
        ackDelay = 200;
        t0 = toggleCnt;
        applyStimulus(8'h3C);
        i_data  = 8'hC3;
        i_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checkOutput($sformatf("bp_ready_c%0d", c), o_ready,  0);
            checkOutput($sformatf("bp_data_c%0d", c),  out_data, 8'h3C);
            @(negedge i_clk);
        end
        checkOutput("bp_toggles_during_wait", toggleCnt - t0, 1);
        i_valid = 1'b0;
        waitReady(100);
        ackDelay = 3;
        checkOutput("bp_tok_cnt", o_tok_cnt, 9);
        checkOutput("bp_reqR",    out_reqR,  1);

        // Counter wrap and protocol error
        applyReset();
        for (int k = 0; k < 17; k++) applyStimulus(8'(k + 8'h10));
        waitReady(100);
        checkOutput("wrap_tok_cnt",   o_tok_cnt,   1);
        checkOutput("wrap_proto_err", o_proto_err, 0);
        errInject = 1'b1;
        repeat (4) @(negedge i_clk);
        checkOutput("err_set",     o_proto_err, 1);
        checkOutput("err_ready",   o_ready,     1);
        checkOutput("err_tok_cnt", o_tok_cnt,   1);
        repeat (10) @(negedge i_clk);
        checkOutput("err_sticky", o_proto_err, 1);

        // Reset in the middle of a handshake
        applyReset();
        applyStimulus(8'h5A);
        @(negedge i_clk);
        checkOutput("mid_reqR_before", out_reqR, 1);
        checkOutput("mid_busy_before", o_busy,   1);
        #2 i_rstn = 1'b0;
        #1;
        checkOutput("mid_rst_reqR",      out_reqR,    0);
        checkOutput("mid_rst_data",      out_data,    0);
        checkOutput("mid_rst_ready",     o_ready,     1);
        checkOutput("mid_rst_busy",      o_busy,      0);
        checkOutput("mid_rst_tok_cnt",   o_tok_cnt,   0);
        checkOutput("mid_rst_proto_err", o_proto_err, 0);
        @(negedge i_clk);
        #2 i_rstn = 1'b1;
        @(negedge i_clk);
        sinkData.delete();
        applyStimulus(8'h77);
        waitReady(100);
        checkOutput("mid_after_tok_cnt",   o_tok_cnt,   1);
        checkOutput("mid_after_proto_err", o_proto_err, 0);
        checkOutput("mid_after_sink",      sinkData.size() > 0 ? sinkData[0] : 8'h00, 8'h77);

        repeat (2) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
